// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: captures two W-bit operands, adds one 4-bit slice
// per cycle LSB first, then holds sum/cout/ovf until the consumer takes them.
module nsa_nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_rca
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);
  localparam int CW = $clog2(NIBBLES) + 1;
  // Index width kept >= 1 so NIBBLES=1 still has a legal select.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [NIBBLES-1:0][3:0]   a_q, b_q, sum_q;
  logic                      carry_q, cout_q, ovf_q;
  logic [CW-1:0]             cnt_q;
  logic [IW-1:0]             idx;
  logic [3:0]                nsum;
  logic                      nco, last;

  assign idx  = cnt_q[IW-1:0];
  assign last = (cnt_q == CW'(NIBBLES - 1));

  nsa_nibble_add u_add (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry_q),
    .s  (nsum),
    .co (nco)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          cnt_q   <= '0;
        end
        RUN: begin
          sum_q[idx] <= nsum;
          carry_q    <= nco;
          cnt_q      <= cnt_q + CW'(1);
          // On the top slice nsum[3] is the sum MSB, so overflow resolves here.
          if (last) begin
            cout_q <= nco;
            ovf_q  <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                      (nsum[3] != a_q[NIBBLES-1][3]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at NIBBLES=4 with hand-computed results.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;

  int n_chk  = 0;
  int n_pass = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("ready_before_start", in_ready, 1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_ready_low_in_run"}, in_ready, 0);
      tick(); lat++;
    end
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_ready_low_in_done"}, in_ready, 0);
  endtask

  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                    input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    start_op(ta, tb_, tc);
    wait_done(tag);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_retain_sum"}, sum, es);
    chk({tag, "_retain_cout"}, cout, ec);
  endtask

  initial begin
    logic [W-1:0] hold_sum;
    logic         hold_c, hold_o;

    // Reset state, held across clock edges.
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;

    op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    op("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    op("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op("mixed",  16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles, then delivered.
    out_ready = 1'b0;
    start_op(16'h1234, 16'h1111, 1'b0);
    wait_done("bp");
    hold_sum = sum; hold_c = cout; hold_o = ovf;
    chk("bp_sum", hold_sum, 16'h2345);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_ready_low", in_ready, 0);
      chk("bp_sum_hold", sum, 16'h2345);
      chk("bp_cout_hold", cout, 0);
      chk("bp_ovf_hold", ovf, 0);
    end
    // Offer new operands on the delivery edge: they must not be taken.
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h0101; b = 16'h0101;
    tick();
    chk("bp_deliver_idle", busy, 0);
    chk("bp_deliver_ready", in_ready, 1);
    chk("bp_deliver_valid", out_valid, 0);
    in_valid = 1'b0;

    // Operands presented during RUN are ignored.
    start_op(16'h0005, 16'h0003, 1'b0);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1;
    wait_done("ign");
    in_valid = 1'b0;
    chk("ign_sum", sum, 16'h0008);
    chk("ign_cout", cout, 0);
    chk("ign_ovf", ovf, 0);
    tick();

    // Reset two cycles into RUN aborts; first edge after release accepts.
    start_op(16'h1234, 16'h4321, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    tick();
    chk("abort_busy_hold", busy, 0);
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_accept", busy, 1);
    wait_done("post_rst");
    chk("post_rst_sum", sum, 16'h0002);
    chk("post_rst_cout", cout, 0);
    chk("post_rst_ovf", ovf, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
